// File: rtl/irq_trap_if.sv
// Bundle of EX-stage, CSR and PC-redirect signals around the trap controller.
// master: EX stage / peripherals / CSR file side; slave: irq_trap_ctrl.
interface irq_trap_if #(
    parameter int NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] irq_i;
    logic               ecall_i;
    logic               mret_i;
    logic [31:0]        inst_addr_i;
    logic               jump_i;
    logic [31:0]        jump_addr_i;
    logic [31:0]        csr_mtvec_i;
    logic [31:0]        csr_mepc_i;
    logic [31:0]        csr_mstatus_i;
    logic               csr_we_o;
    logic [11:0]        csr_waddr_o;
    logic [31:0]        csr_wdata_o;
    logic               hold_o;
    logic               int_assert_o;
    logic [31:0]        int_addr_o;

    modport master (
        output irq_i, ecall_i, mret_i, inst_addr_i, jump_i, jump_addr_i,
               csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        input  csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o, int_addr_o
    );

    modport slave (
        input  irq_i, ecall_i, mret_i, inst_addr_i, jump_i, jump_addr_i,
               csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        output csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o, int_addr_o
    );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Interrupt / ecall / mret arbiter beside the execute stage. Stalls the
// pipeline, writes mepc/mcause/mstatus through the CSR port one per cycle,
// then pulses a PC redirect to mtvec (trap) or mepc (mret).
//
//  state      | meaning
//  -----------+-------------------------------------------------
//  S_IDLE     | watching for ecall/mret/irq; only state that detects
//  S_W_MEPC   | trap: writing mepc
//  S_W_MCAUSE | trap: writing mcause
//  S_W_MSTAT  | trap: writing mstatus (MPIE<=MIE, MIE<=0)
//  S_R_MSTAT  | mret: writing mstatus (MIE<=MPIE, MPIE<=1)
//  S_JUMP     | one-cycle redirect pulse, no CSR write
module irq_trap_ctrl #(
    parameter int NUM_IRQ    = 4,
    parameter int CAUSE_BASE = 7
) (
    input  logic      clk,
    input  logic      rst_n,
    irq_trap_if.slave bus
);

    localparam int          IDX_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTAT,
        S_R_MSTAT,
        S_JUMP
    } state_t;

    state_t state_q, state_d;

    logic [NUM_IRQ-1:0] irq_masked;
    logic               irq_hit;
    logic [IDX_W-1:0]   irq_idx;
    logic               is_idle;
    logic               take_ecall, take_mret, take_irq, event_det;
    logic [31:0]        mepc_val, cause_val;

    logic [31:0]        cause_q, mstat_q;
    logic [31:0]        mstat_trap, mstat_mret;

    logic               csr_we_d;
    logic [11:0]        csr_waddr_d;
    logic [31:0]        csr_wdata_d;
    logic               int_assert_d;
    logic [31:0]        int_addr_d;

    logic               csr_we_q;
    logic [11:0]        csr_waddr_q;
    logic [31:0]        csr_wdata_q;
    logic               int_assert_q;
    logic [31:0]        int_addr_q;

    // Event detection in IDLE: MIE-gated lowest-index IRQ, ecall > mret > irq.
    always_comb begin
        irq_masked = bus.irq_i & {NUM_IRQ{bus.csr_mstatus_i[3]}};
        irq_hit    = 1'b0;
        irq_idx    = '0;
        // Scan downward so the lowest set index is the one left standing.
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (irq_masked[k]) begin
                irq_hit = 1'b1;
                irq_idx = k[IDX_W-1:0];
            end
        end
        // Detection is gated by reset so the stall stays low while in reset.
        is_idle    = (state_q == S_IDLE);
        take_ecall = rst_n && is_idle && bus.ecall_i;
        take_mret  = rst_n && is_idle && !bus.ecall_i && bus.mret_i;
        take_irq   = rst_n && is_idle && !bus.ecall_i && !bus.mret_i && irq_hit;
        event_det  = take_ecall || take_mret || take_irq;

        // ecall resumes after itself; an IRQ resumes at the EX instruction's
        // real successor, which is the jump target if it was redirecting.
        if (bus.ecall_i)
            mepc_val = bus.inst_addr_i + 32'd4;
        else if (bus.jump_i)
            mepc_val = bus.jump_addr_i;
        else
            mepc_val = bus.inst_addr_i;

        if (bus.ecall_i)
            cause_val = 32'd11;
        else
            cause_val = {1'b1, 31'(CAUSE_BASE + 32'(irq_idx))};
    end

    // mstatus rewrite values for trap entry (from snapshot) and mret (live at detect).
    always_comb begin
        mstat_trap    = mstat_q;
        mstat_trap[7] = mstat_q[3];
        mstat_trap[3] = 1'b0;
        mstat_mret    = bus.csr_mstatus_i;
        mstat_mret[3] = bus.csr_mstatus_i[7];
        mstat_mret[7] = 1'b1;
    end

    // Next-state logic for both the trap and mret sequences.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take_ecall || take_irq)
                    state_d = S_W_MEPC;
                else if (take_mret)
                    state_d = S_R_MSTAT;
            end
            S_W_MEPC:   state_d = S_W_MCAUSE;
            S_W_MCAUSE: state_d = S_W_MSTAT;
            S_W_MSTAT:  state_d = S_JUMP;
            S_R_MSTAT:  state_d = S_JUMP;
            S_JUMP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output values for the state being entered, so they register alongside it.
    always_comb begin
        csr_we_d     = 1'b0;
        csr_waddr_d  = 12'h000;
        csr_wdata_d  = 32'h0;
        int_assert_d = 1'b0;
        int_addr_d   = 32'h0;
        case (state_d)
            S_W_MEPC: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MEPC;
                csr_wdata_d = mepc_val;
            end
            S_W_MCAUSE: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MCAUSE;
                csr_wdata_d = cause_q;
            end
            S_W_MSTAT: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MSTATUS;
                csr_wdata_d = mstat_trap;
            end
            S_R_MSTAT: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MSTATUS;
                csr_wdata_d = mstat_mret;
            end
            S_JUMP: begin
                int_assert_d = 1'b1;
                int_addr_d   = (state_q == S_R_MSTAT) ? bus.csr_mepc_i : bus.csr_mtvec_i;
            end
            default: ;
        endcase
    end

    // State, detect-time snapshots and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cause_q      <= 32'h0;
            mstat_q      <= 32'h0;
            csr_we_q     <= 1'b0;
            csr_waddr_q  <= 12'h000;
            csr_wdata_q  <= 32'h0;
            int_assert_q <= 1'b0;
            int_addr_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            csr_we_q     <= csr_we_d;
            csr_waddr_q  <= csr_waddr_d;
            csr_wdata_q  <= csr_wdata_d;
            int_assert_q <= int_assert_d;
            int_addr_q   <= int_addr_d;
            if (event_det) begin
                cause_q <= cause_val;
                mstat_q <= bus.csr_mstatus_i;
            end
        end
    end

    assign bus.csr_we_o     = csr_we_q;
    assign bus.csr_waddr_o  = csr_waddr_q;
    assign bus.csr_wdata_o  = csr_wdata_q;
    assign bus.int_assert_o = int_assert_q;
    assign bus.int_addr_o   = int_addr_q;
    // Combinational so the detect cycle itself already stalls the pipeline.
    assign bus.hold_o       = (state_q != S_IDLE) || event_det;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl: directed scenarios plus randomized
// events checked against a transaction-level model of the trap/mret rules.
module tb_irq_trap_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    irq_trap_if #(.NUM_IRQ(4)) bus ();

    irq_trap_ctrl #(.NUM_IRQ(4), .CAUSE_BASE(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mtvec_v;
    logic [31:0] mepc_v;

    task automatic quiet_inputs();
        bus.irq_i   = 4'h0;
        bus.ecall_i = 1'b0;
        bus.mret_i  = 1'b0;
        bus.jump_i  = 1'b0;
    endtask

    // Drives one candidate event in an IDLE cycle, then follows the whole sequence.
    task automatic apply_event(input logic [3:0] irq, input logic ec, input logic mr,
                               input logic [31:0] pc, input logic jmp, input logic [31:0] jaddr,
                               input logic [31:0] mst, input logic noise, input string tag);
        int          kind;
        int          idx;
        int          len;
        logic [43:0] exp_q[$];
        logic [43:0] got;
        logic [43:0] want;
        logic [31:0] exp_addr;
        logic [31:0] mepc_e;
        logic [31:0] cause_e;

        kind = 0;
        idx  = -1;
        for (int i = 0; i < 4; i++)
            if (irq[i] && idx < 0) idx = i;
        if (ec) kind = 1;
        else if (mr) kind = 2;
        else if (mst[3] && idx >= 0) kind = 3;

        exp_addr = 32'h0;
        len = 0;
        if (kind == 1 || kind == 3) begin
            mepc_e  = ec ? pc + 32'd4 : (jmp ? jaddr : pc);
            cause_e = ec ? 32'd11 : (32'h8000_0000 | 32'(7 + idx));
            exp_q.push_back({12'h341, mepc_e});
            exp_q.push_back({12'h342, cause_e});
            exp_q.push_back({12'h300, (mst & ~32'h88) | (mst[3] ? 32'h80 : 32'h0)});
            exp_addr = mtvec_v;
            len = 4;
        end else if (kind == 2) begin
            exp_q.push_back({12'h300, (mst & ~32'h88) | 32'h80 | (mst[7] ? 32'h8 : 32'h0)});
            exp_addr = mepc_v;
            len = 2;
        end

        @(posedge clk); #1;
        bus.irq_i = irq; bus.ecall_i = ec; bus.mret_i = mr;
        bus.inst_addr_i = pc; bus.jump_i = jmp; bus.jump_addr_i = jaddr;
        bus.csr_mstatus_i = mst;
        @(negedge clk);
        total_cnt++;
        if (bus.hold_o !== (kind != 0))
            $display("FAIL %s detect_hold: got %0b want %0b", tag, bus.hold_o, (kind != 0));
        else pass_cnt++;

        if (kind == 0) begin
            @(posedge clk); #1; quiet_inputs();
            @(negedge clk);
            total_cnt++;
            if (bus.csr_we_o !== 1'b0 || bus.int_assert_o !== 1'b0)
                $display("FAIL %s no_event: we %0b assert %0b want 0 0", tag, bus.csr_we_o, bus.int_assert_o);
            else pass_cnt++;
            return;
        end

        for (int k = 1; k <= len + 1; k++) begin
            @(posedge clk); #1;
            if (k <= len && noise) begin
                bus.irq_i   = 4'($urandom_range(0, 15));
                bus.ecall_i = 1'($urandom_range(0, 1));
                bus.mret_i  = 1'($urandom_range(0, 1));
                bus.jump_i  = 1'($urandom_range(0, 1));
            end else if (k > len) begin
                quiet_inputs();
            end
            @(negedge clk);
            if (bus.csr_we_o === 1'b1) begin
                got = {bus.csr_waddr_o, bus.csr_wdata_o};
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s extra_write: got %h want none (cycle %0d)", tag, got, k);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want)
                        $display("FAIL %s csr_write: got %h want %h (cycle %0d)", tag, got, want, k);
                    else pass_cnt++;
                end
            end
            total_cnt++;
            if (bus.int_assert_o !== (k == len))
                $display("FAIL %s int_assert: got %0b want %0b (cycle %0d)", tag, bus.int_assert_o, (k == len), k);
            else pass_cnt++;
            if (k == len) begin
                total_cnt++;
                if (bus.int_addr_o !== exp_addr)
                    $display("FAIL %s int_addr: got %h want %h", tag, bus.int_addr_o, exp_addr);
                else pass_cnt++;
            end
            total_cnt++;
            if (bus.hold_o !== (k <= len))
                $display("FAIL %s hold: got %0b want %0b (cycle %0d)", tag, bus.hold_o, (k <= len), k);
            else pass_cnt++;
        end
        total_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL %s missing_writes: got %0d outstanding want 0", tag, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.irq_i = 4'hF; bus.ecall_i = 1'b0; bus.mret_i = 1'b0; bus.jump_i = 1'b0;
        bus.csr_mstatus_i = 32'h8;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.int_assert_o, bus.int_addr_o, bus.hold_o} !== '0)
            $display("FAIL reset_outputs: we %0b waddr %h wdata %h assert %0b addr %h hold %0b want all 0",
                     bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.int_assert_o, bus.int_addr_o, bus.hold_o);
        else pass_cnt++;
        @(posedge clk); #1;
        bus.csr_mstatus_i = 32'h0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.hold_o !== 1'b0 || bus.csr_we_o !== 1'b0 || bus.int_assert_o !== 1'b0)
                $display("FAIL reset_mie0: hold %0b we %0b assert %0b want 0 0 0", bus.hold_o, bus.csr_we_o, bus.int_assert_o);
            else pass_cnt++;
        end
        @(posedge clk); #1; quiet_inputs();
    endtask

    task automatic test_timer_irq();
        mtvec_v = 32'h100; bus.csr_mtvec_i = mtvec_v;
        apply_event(4'b0001, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0, 32'h8, 1'b0, "timer_irq");
    endtask

    task automatic test_ecall();
        apply_event(4'b0000, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 32'h0, 1'b0, "ecall");
    endtask

    task automatic test_mret();
        mepc_v = 32'h84; bus.csr_mepc_i = mepc_v;
        apply_event(4'b0000, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 32'h80, 1'b0, "mret");
    endtask

    task automatic test_priority();
        apply_event(4'b0110, 1'b1, 1'b0, 32'h400, 1'b1, 32'h500, 32'h8, 1'b0, "prio_ecall");
        apply_event(4'b0110, 1'b0, 1'b0, 32'h400, 1'b1, 32'h500, 32'h8, 1'b0, "prio_irq");
        apply_event(4'b0110, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 32'h8, 1'b0, "prio_mret");
    endtask

    task automatic test_midseq_reset();
        @(posedge clk); #1;
        bus.ecall_i = 1'b1; bus.inst_addr_i = 32'h300;
        @(posedge clk); #1; quiet_inputs();
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.csr_we_o !== 1'b1 || bus.csr_waddr_o !== 12'h342)
            $display("FAIL midreset_mcause: we %0b waddr %h want 1 342", bus.csr_we_o, bus.csr_waddr_o);
        else pass_cnt++;
        @(posedge clk); #1; rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.int_assert_o !== 1'b0 || bus.csr_we_o !== 1'b0 || bus.hold_o !== 1'b0)
                $display("FAIL midreset_idle: assert %0b we %0b hold %0b want 0 0 0 (cycle %0d)",
                         bus.int_assert_o, bus.csr_we_o, bus.hold_o, k);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_midseq_toggle();
        apply_event(4'b0100, 1'b0, 1'b0, 32'h640, 1'b0, 32'h0, 32'h8, 1'b1, "toggle_irq");
        apply_event(4'b0000, 1'b0, 1'b1, 32'h640, 1'b0, 32'h0, 32'h00, 1'b1, "toggle_mret");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            mtvec_v = $urandom & 32'hFFFF_FFFC; bus.csr_mtvec_i = mtvec_v;
            mepc_v  = $urandom;                 bus.csr_mepc_i  = mepc_v;
            apply_event(4'($urandom_range(0, 15)),
                        ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 3) == 0),
                        (n % 7 == 0) ? 32'hFFFF_FFFC : $urandom,
                        1'($urandom_range(0, 1)),
                        $urandom,
                        $urandom,
                        1'($urandom_range(0, 1)),
                        "random");
        end
    endtask

    initial begin
        quiet_inputs();
        bus.inst_addr_i = 32'h0; bus.jump_addr_i = 32'h0;
        mtvec_v = 32'h0; mepc_v = 32'h0;
        bus.csr_mtvec_i = 32'h0; bus.csr_mepc_i = 32'h0; bus.csr_mstatus_i = 32'h0;
        test_reset();
        test_timer_irq();
        test_ecall();
        test_mret();
        test_priority();
        test_midseq_reset();
        test_midseq_toggle();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
